sram_arbiter: RTL
=================

# sram_arbiter

Two-master OBI arbiter sharing the single read/write data port (`sram_d`) of the SRAM wrapper between the core data port (master 0) and the SPI-cache refill/writeback engine (master 1). It selects one request per cycle, with fixed priority to master 0 and a starvation guard for master 1. It routes the 1-cycle-latency read response back to the master that issued it. An optional bus lock keeps multi-word refills atomic.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive cycles master 1 may be denied while requesting before it is forced to win. Legal range ≥1.
- `CNT_W`, default `$clog2(STARVE_LIMIT+1)`: width of the starvation counter.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  synchronous reset, active-high.
- `m0_req_i, m0_we_i`  in  1  master 0 request and write-enable.
- `m0_addr_i, m0_wdata_i`  in  32  master 0 address and write data.
- `m0_be_i`  in  4  master 0 byte enables.
- `m0_gnt_o, m0_rvalid_o`  out  1  master 0 grant and response valid.
- `m0_rdata_o`  out  32  master 0 read data.
- `m1_*`  same set of ports as `m0_*`  master 1 (SPI cache).
- `m1_lock_i`  in  1  master 1 lock request; only honoured when `SRAM_ARB_LOCK_EN` is defined.
- `s_req_o, s_we_o`  out  1  request and write-enable to `sram_d`.
- `s_addr_o, s_wdata_o`  out  32  address and write data to `sram_d`.
- `s_be_o`  out  4  byte enables to `sram_d`.
- `s_gnt_i, s_rvalid_i`  in  1  grant and response valid from `sram_d`.
- `s_rdata_i`  in  32  read data from `sram_d`.
- `owner_o`  out  1  master currently selected (0/1); informational.

## Operation
- Selection each cycle, evaluated combinationally:
  - If `locked_q` is set, select master 1.
  - Otherwise, if `m1_req_i` is high and `starve_q == STARVE_LIMIT`, select master 1.
  - Otherwise, if `m0_req_i` is high, select master 0.
  - Otherwise, if `m1_req_i` is high, select master 1.
  - Otherwise, no selection.
- Slave mux: `s_req_o`, `s_addr_o`, `s_we_o`, `s_be_o` and `s_wdata_o` carry the selected master's signals. When nothing is selected, all of them are 0.
- Grants: `mX_gnt_o = selected==X && s_gnt_i`. The non-selected master sees gnt=0 and must hold its request stable (OBI rule).
- Starvation counter `starve_q` (CNT_W bits):
  - Increments (saturating at `STARVE_LIMIT`) in a cycle where `m1_req_i=1` and `m1_gnt_o=0`.
  - Clears when `m1_gnt_o=1` or `m1_req_i=0`.
- Response routing: on every accepted transfer (`s_req_o && s_gnt_i`), register `pend_q<=1` and `rsp_owner_q<=selected`; otherwise `pend_q<=0`.
  - `mX_rvalid_o = s_rvalid_i && pend_q && rsp_owner_q==X`.
  - `mX_rdata_o = s_rdata_i` when that master's rvalid is high, else 0.
  - Write responses (rvalid with no meaningful data) are routed the same way.
- Back-to-back transfers alternate masters with no bubble; each response returns exactly 1 cycle after its grant.
- Reset behaviour while `rst_i=1`:
  - Outputs: `s_req_o=0`, both `mX_gnt_o=0`, both `mX_rvalid_o=0`, both `mX_rdata_o=0`, `owner_o=0`.
  - State: `pend_q=0`, `rsp_owner_q=0`, `starve_q=0`, `locked_q=0`.
  - A response in flight when reset asserts is dropped; any `s_rvalid_i` in the first cycle after reset is ignored.
- Simultaneous `m0_req_i` and `m1_req_i` with the counter below the limit: master 0 wins and `starve_q` increments.

## Timing
- Request to grant: combinational, 0 cycles, passing through `s_gnt_i`. `sram_d` grants in the same cycle as the request.
- Grant to rvalid: exactly 1 cycle. `rsp_owner_q` is a single stage because the SRAM never has more than one response outstanding.
- Worst-case master-1 wait under continuous master-0 traffic: `STARVE_LIMIT` cycles. It is granted on cycle `STARVE_LIMIT+1`.
- Worst-case master-0 wait with the lock feature compiled out: 1 cycle.

## Configuration
- `SRAM_ARB_LOCK_EN` defined:
  - When master 1 is granted with `m1_lock_i=1`, set `locked_q` on that edge.
  - While `locked_q=1`, master 0 is never selected.
  - `locked_q` clears on the edge where master 1 is granted with `m1_lock_i=0` (the last beat).
  - Reset clears `locked_q`.
- `SRAM_ARB_LOCK_EN` undefined: `m1_lock_i` is ignored (terminated as unused) and `locked_q` is constant 0.

## Test plan
- Master 0 only: read 0x8000_0010 → `m0_gnt_o` high in the same cycle; next cycle `m0_rvalid_o=1` with `m0_rdata_o` equal to the SRAM word; `m1_rvalid_o=0`.
- Both masters requesting continuously, `STARVE_LIMIT=4` → master 0 granted on cycles 0–3, master 1 on cycle 4, master 0 again on cycle 5. Each rvalid goes to the correct master with 1-cycle latency.
- Alternating grants: m0 writes 0xCAFE_0001 to 0x8000_0004, then m1 reads 0x8000_0004 in the next cycle → `m1_rdata_o=0xCAFE_0001`; no rvalid is misrouted.
- With `SRAM_ARB_LOCK_EN` defined: m1 issues a 4-beat refill with lock high on beats 0–2 and low on beat 3, while m0 requests throughout → m0 is not granted until the cycle after beat 3. Without the macro, m0 wins beat 1.
- `rst_i` asserted in the cycle after an m1 grant → `m1_rvalid_o` stays 0. After reset, `starve_q=0` and master 0 wins the first contended cycle.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-master OBI arbiter for the SRAM data port: master 0 has priority, master 1 has a starvation guard.
// Optional master-1 bus lock is compiled in with `define SRAM_ARB_LOCK_EN.
module sram_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_be_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_be_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  input  logic        m1_lock_i,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_be_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  output logic        owner_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic             pend_q;
  logic             rsp_owner_q;
  logic             locked_q;
  logic [CNT_W-1:0] starve_q;
  logic             sel_valid;
  logic             sel_m1;
  logic             accept;

  // Selection: lock, then starvation override, then fixed priority to master 0.
  always_comb begin
    sel_valid = 1'b0;
    sel_m1    = 1'b0;
    if (rst_i) begin
      sel_valid = 1'b0;
      sel_m1    = 1'b0;
    end else if (locked_q) begin
      sel_valid = 1'b1;
      sel_m1    = 1'b1;
    end else if (m1_req_i && (starve_q == LIMIT)) begin
      sel_valid = 1'b1;
      sel_m1    = 1'b1;
    end else if (m0_req_i) begin
      sel_valid = 1'b1;
      sel_m1    = 1'b0;
    end else if (m1_req_i) begin
      sel_valid = 1'b1;
      sel_m1    = 1'b1;
    end else begin
      sel_valid = 1'b0;
      sel_m1    = 1'b0;
    end
  end

  // Slave-side request mux; all-zero when nothing is selected.
  always_comb begin
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = 32'h0000_0000;
    s_wdata_o = 32'h0000_0000;
    s_be_o    = 4'h0;
    if (sel_valid && sel_m1) begin
      s_req_o   = m1_req_i;
      s_we_o    = m1_we_i;
      s_addr_o  = m1_addr_i;
      s_wdata_o = m1_wdata_i;
      s_be_o    = m1_be_i;
    end else if (sel_valid) begin
      s_req_o   = m0_req_i;
      s_we_o    = m0_we_i;
      s_addr_o  = m0_addr_i;
      s_wdata_o = m0_wdata_i;
      s_be_o    = m0_be_i;
    end else begin
      s_req_o   = 1'b0;
    end
  end

  assign accept      = s_req_o & s_gnt_i;
  assign m0_gnt_o    = accept & ~sel_m1;
  assign m1_gnt_o    = accept & sel_m1;
  assign owner_o     = sel_m1;

  // Only one response is ever outstanding, so a single owner bit routes it.
  assign m0_rvalid_o = ~rst_i & s_rvalid_i & pend_q & ~rsp_owner_q;
  assign m1_rvalid_o = ~rst_i & s_rvalid_i & pend_q & rsp_owner_q;
  assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : 32'h0000_0000;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : 32'h0000_0000;

  // Response tracking and master-1 starvation counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q      <= 1'b0;
      rsp_owner_q <= 1'b0;
      starve_q    <= {CNT_W{1'b0}};
    end else begin
      pend_q <= accept;
      if (accept) begin
        rsp_owner_q <= sel_m1;
      end else begin
        rsp_owner_q <= rsp_owner_q;
      end
      if (m1_req_i && !m1_gnt_o) begin
        if (starve_q < LIMIT) begin
          starve_q <= starve_q + ONE;
        end else begin
          starve_q <= LIMIT;
        end
      end else begin
        starve_q <= {CNT_W{1'b0}};
      end
    end
  end

`ifdef SRAM_ARB_LOCK_EN
  // Every master-1 grant loads the lock; the last beat of a burst drops it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked_q <= 1'b0;
    end else if (m1_gnt_o) begin
      locked_q <= m1_lock_i;
    end else begin
      locked_q <= locked_q;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = m1_lock_i;
  assign locked_q    = 1'b0;
`endif

endmodule
